encoder8_to_3_drain: RTL and testbench

Sequential 8-to-3 encoder, the inverse of the team's 3-to-8 one-hot decoders. It captures an 8-bit request vector and emits the 3-bit index of every set bit, one per valid/ready handshake, in a fixed priority order. It then pulses `done`. It sits between a one-hot/multi-hot request source (interrupt lines, decoder outputs, status flags) and a consumer that accepts binary indices one at a time.

---
 rtl/encoder8_to_3_drain.sv | 88 ++++++++
 tb/tb_encoder8_to_3_drain.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/encoder8_to_3_drain.sv
// Sequential 8-to-3 encoder: captures a multi-hot request vector and offers the
// index of each set bit, one per valid/ready handshake, then pulses done.
module encoder8_to_3_drain #(
  parameter bit PRIORITY_HIGH = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] in,
  output logic [2:0] out,
  output logic       valid,
  input  logic       ready,
  output logic       last,
  output logic       busy,
  output logic       done
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t     state;
  logic [7:0] pending;
  logic [2:0] sel;
  logic       single;
  logic       fire;

  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [2:0] highest_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic one_bit(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  assign sel    = PRIORITY_HIGH ? highest_idx(pending) : lowest_idx(pending);
  assign single = one_bit(pending);

  // Outputs decode registered state; only valid also sees en, so draining pauses instantly.
  assign busy  = (state == DRAIN);
  assign valid = busy && en;
  assign out   = valid ? sel : 3'd0;
  assign last  = valid && single;
  assign fire  = valid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= 8'd0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load && en) begin
            pending <= in;
            if (in != 8'd0) state <= DRAIN;
            else            done  <= 1'b1;
          end
        end
        DRAIN: begin
          if (fire) begin
            pending <= pending & ~(8'd1 << sel);
            if (single) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder8_to_3_drain.sv
// Scoreboard bench for encoder8_to_3_drain: low-first and high-first instances
// share inputs except load; a monitor pops expected codes and done markers.
module tb_encoder8_to_3_drain;

  typedef struct {
    bit       is_done;
    bit [2:0] idx;
    bit       lst;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, en, ready, load0, load1;
  logic [7:0] in;
  logic [2:0] out0, out1;
  logic       valid0, last0, busy0, done0;
  logic       valid1, last1, busy1, done1;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  encoder8_to_3_drain #(.PRIORITY_HIGH(1'b0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load0), .in(in),
    .out(out0), .valid(valid0), .ready(ready), .last(last0), .busy(busy0), .done(done0)
  );

  encoder8_to_3_drain #(.PRIORITY_HIGH(1'b1)) dut_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load1), .in(in),
    .out(out1), .valid(valid1), .ready(ready), .last(last1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t code(input bit [2:0] idx, input bit lst);
    exp_t e;
    e.is_done = 1'b0; e.idx = idx; e.lst = lst;
    return e;
  endfunction

  function automatic exp_t dmark();
    exp_t e;
    e.is_done = 1'b1; e.idx = 3'd0; e.lst = 1'b0;
    return e;
  endfunction

  // Monitor: handshakes and done pulses are matched in order against the queues.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (done0) begin
        chk("done0_order", (q0.size() > 0 && q0[0].is_done), 1);
        chk("done0_busy", busy0, 0);
        chk("done0_valid", valid0, 0);
        if (q0.size() > 0 && q0[0].is_done) void'(q0.pop_front());
      end
      if (valid0 && ready) begin
        chk("hs0_expected", (q0.size() > 0 && !q0[0].is_done), 1);
        if (q0.size() > 0 && !q0[0].is_done) begin
          e = q0.pop_front();
          chk("out0", out0, e.idx);
          chk("last0", last0, e.lst);
        end
      end
      if (!valid0) chk("out0_idle", {out0, last0}, 0);

      if (done1) begin
        chk("done1_order", (q1.size() > 0 && q1[0].is_done), 1);
        chk("done1_busy", busy1, 0);
        if (q1.size() > 0 && q1[0].is_done) void'(q1.pop_front());
      end
      if (valid1 && ready) begin
        chk("hs1_expected", (q1.size() > 0 && !q1[0].is_done), 1);
        if (q1.size() > 0 && !q1[0].is_done) begin
          e = q1.pop_front();
          chk("out1", out1, e.idx);
          chk("last1", last1, e.lst);
        end
      end
      if (!valid1) chk("out1_idle", {out1, last1}, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drained(input int maxc);
    int c;
    c = 0;
    while ((q0.size() != 0 || q1.size() != 0) && c < maxc) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk("drain_timeout", q0.size() + q1.size(), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n = 1'b0; en = 1'b1; ready = 1'b1; load0 = 1'b0; load1 = 1'b0; in = 8'd0;
    #12;
    chk("rst_out", out0, 0);
    chk("rst_flags", {valid0, last0, busy0, done0}, 0);
    chk("rst_flags_hi", {valid1, last1, busy1, done1}, 0);
    rst_n = 1'b1;
    tick();

    // Basic low-first drain of 1010_0100
    q0.push_back(code(3'd2, 0)); q0.push_back(code(3'd5, 0));
    q0.push_back(code(3'd7, 1)); q0.push_back(dmark());
    load0 = 1'b1; in = 8'b1010_0100;
    tick();
    load0 = 1'b0;
    chk("t1_busy", busy0, 1);
    chk("t1_first", {valid0, out0}, {1'b1, 3'd2});
    c = 0;
    while (!done0 && c < 20) begin tick(); c++; end
    chk("t1_latency", c, 3);
    wait_drained(20);

    // High-first drain of a full vector
    for (int i = 7; i >= 0; i--) q1.push_back(code(3'(i), i == 0));
    q1.push_back(dmark());
    load1 = 1'b1; in = 8'hFF;
    tick();
    load1 = 1'b0;
    chk("t2_first", {valid1, out1}, {1'b1, 3'd7});
    wait_drained(30);

    // Backpressure then pause on 0001_0010
    ready = 1'b0;
    q0.push_back(code(3'd1, 0)); q0.push_back(code(3'd4, 1)); q0.push_back(dmark());
    load0 = 1'b1; in = 8'b0001_0010;
    tick();
    load0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold", {valid0, out0, last0}, {1'b1, 3'd1, 1'b0});
      tick();
    end
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("pause_valid", valid0, 0);
      chk("pause_busy", busy0, 1);
      tick();
    end
    en = 1'b1; ready = 1'b1;
    wait_drained(20);

    // Empty load
    q0.push_back(dmark());
    load0 = 1'b1; in = 8'd0;
    tick();
    load0 = 1'b0;
    chk("empty_done", done0, 1);
    chk("empty_valid", valid0, 0);
    tick();
    chk("empty_after", {valid0, busy0, done0}, 0);
    wait_drained(10);

    // Load during drain is ignored
    q0.push_back(code(3'd1, 0)); q0.push_back(code(3'd2, 1)); q0.push_back(dmark());
    load0 = 1'b1; in = 8'b0000_0110;
    tick();
    in = 8'hFF;
    tick();
    load0 = 1'b0;
    wait_drained(20);

    // New load accepted in the done cycle
    q0.push_back(code(3'd0, 1)); q0.push_back(dmark());
    q0.push_back(code(3'd7, 1)); q0.push_back(dmark());
    load0 = 1'b1; in = 8'b0000_0001;
    tick();
    load0 = 1'b0;
    tick();
    chk("b2b_done", done0, 1);
    load0 = 1'b1; in = 8'b1000_0000;
    tick();
    load0 = 1'b0;
    chk("b2b_next", {valid0, out0, last0}, {1'b1, 3'd7, 1'b1});
    wait_drained(20);

    // Reset mid-drain
    ready = 1'b0;
    q0.push_back(code(3'd4, 0));
    load0 = 1'b1; in = 8'b1111_0000;
    tick();
    load0 = 1'b0; ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("pre_rst_out", out0, 5);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out", out0, 0);
    chk("rst_mid_flags", {valid0, last0, busy0, done0}, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_no_done", done0, 0);
    end
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {busy0, done0}, 0);
    q0.push_back(code(3'd3, 1)); q0.push_back(dmark());
    load0 = 1'b1; in = 8'b0000_1000;
    tick();
    load0 = 1'b0;
    chk("post_rst_code", {valid0, out0, last0}, {1'b1, 3'd3, 1'b1});
    ready = 1'b1;
    wait_drained(20);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
